// File: rtl/dlyc_cal_pkg.sv
// Shared types, defaults and helpers for the delay-chain calibration controller.
package dlyc_cal_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_CAPT   = 3'd2,
      ST_EVAL   = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_FINISH = 3'd5
   } cal_state_e;

   localparam int FILT_DEF    = 4;
   localparam int MAXITER_DEF = 16;

   function automatic int code_width(input int ntaps);
      return $clog2(ntaps + 1);
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/dlyc_therm_dec.sv
// Thermometer decoder: counts leading ones from tap0 and flags any 1 above the first 0.
module dlyc_therm_dec
   import dlyc_cal_pkg::*;
#(
   parameter int NTAPS = 16,
   parameter int CW    = code_width(NTAPS)
) (
   input  logic [NTAPS-1:0] taps,
   output logic [CW-1:0]    meas,
   output logic             bubble
);

   logic seen_zero_s;

   // Scan from tap0 upward; a set tap after a clear one is a bubble and is not counted.
   always_comb begin
      meas        = '0;
      bubble      = 1'b0;
      seen_zero_s = 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
         if (!taps[i]) begin
            seen_zero_s = 1'b1;
         end else if (seen_zero_s) begin
            bubble = 1'b1;
         end else begin
            meas = meas + {{(CW-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/dlyc_chain_cal.sv
// Delay-chain calibration controller: launch, capture, filter, publish tap count.
// Define DLYC_CAL_GRAY_EN to present CODE Gray-encoded for a foreign clock domain.
module dlyc_chain_cal
   import dlyc_cal_pkg::*;
#(
   parameter int NTAPS   = 16,
   parameter int CW      = code_width(NTAPS),
   parameter int FILT    = FILT_DEF,
   parameter int MAXITER = MAXITER_DEF,
   parameter int CLR_TMO = 15
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             START,
   output logic             LAUNCH,
   input  logic [NTAPS-1:0] TAPS,
   output logic             BUSY,
   output logic             DONE,
   output logic [CW-1:0]    CODE,
   output logic             CODE_VLD,
   output logic             ERR,
   inout  wire              VDD,
   inout  wire              VSS
);

   localparam int MW = $clog2(FILT + 1);
   localparam int IW = $clog2(MAXITER + 1);
   localparam int TW = $clog2(CLR_TMO + 1);
   localparam logic [MW-1:0] M_ONE = {{(MW-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0] I_ONE = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

   cal_state_e       state_r, state_nxt;
   logic             launch_r, launch_nxt;
   logic [NTAPS-1:0] cap_r, cap_nxt, smp_r;
   logic [CW-1:0]    prev_r, prev_nxt, code_r, code_nxt, code_enc_s, meas_s;
   logic [MW-1:0]    match_r, match_nxt;
   logic [IW-1:0]    iter_r, iter_nxt;
   logic [TW-1:0]    dcnt_r, dcnt_nxt;
   logic             err_r, err_nxt, ok_r, ok_nxt, busy_r, busy_nxt;
   logic             done_r, done_nxt, vld_r, vld_nxt, bubble_s;

   dlyc_therm_dec #(.NTAPS(NTAPS), .CW(CW)) u_dec (
      .taps   (cap_r),
      .meas   (meas_s),
      .bubble (bubble_s)
   );

`ifdef DLYC_CAL_GRAY_EN
   assign code_enc_s = CW'(bin2gray(32'(prev_r)));
`else
   assign code_enc_s = prev_r;
`endif

   // Next-state and next-value logic for the whole calibration sequence.
   always_comb begin
      state_nxt  = state_r;
      launch_nxt = launch_r;
      cap_nxt    = cap_r;
      prev_nxt   = prev_r;
      match_nxt  = match_r;
      iter_nxt   = iter_r;
      dcnt_nxt   = dcnt_r;
      err_nxt    = err_r;
      ok_nxt     = ok_r;
      code_nxt   = code_r;
      vld_nxt    = vld_r;
      done_nxt   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_nxt = ST_LAUNCH;
               err_nxt   = 1'b0;
               iter_nxt  = '0;
               match_nxt = '0;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            launch_nxt = 1'b1;
            state_nxt  = ST_CAPT;
         end
         ST_CAPT: begin
            cap_nxt   = TAPS;
            state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            if (bubble_s) begin
               err_nxt = 1'b1;
            end else begin
               err_nxt = err_r;
            end
            if (meas_s == prev_r) begin
               match_nxt = match_r + M_ONE;
            end else begin
               match_nxt = M_ONE;
               prev_nxt  = meas_s;
            end
            iter_nxt  = iter_r + I_ONE;
            dcnt_nxt  = '0;
            state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            launch_nxt = 1'b0;
            // Leave once the chain reads empty, or give up after CLR_TMO cycles here.
            if ((smp_r == '0) || (dcnt_r == TW'(CLR_TMO - 1))) begin
               if (smp_r != '0) begin
                  err_nxt = 1'b1;
               end else begin
                  err_nxt = err_r;
               end
               if (match_r == MW'(FILT)) begin
                  ok_nxt    = 1'b1;
                  state_nxt = ST_FINISH;
               end else if (iter_r == IW'(MAXITER)) begin
                  ok_nxt    = 1'b0;
                  err_nxt   = 1'b1;
                  state_nxt = ST_FINISH;
               end else begin
                  state_nxt = ST_LAUNCH;
               end
            end else begin
               dcnt_nxt = dcnt_r + T_ONE;
            end
         end
         ST_FINISH: begin
            if (ok_r) begin
               code_nxt = code_enc_s;
               vld_nxt  = 1'b1;
            end else begin
               code_nxt = code_r;
               vld_nxt  = vld_r;
            end
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Datapath, counters and registered outputs; TAPS is resampled every cycle for the drain check.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         launch_r <= 1'b0;
         cap_r    <= '0;
         smp_r    <= '0;
         prev_r   <= '0;
         match_r  <= '0;
         iter_r   <= '0;
         dcnt_r   <= '0;
         err_r    <= 1'b0;
         ok_r     <= 1'b0;
         code_r   <= '0;
         vld_r    <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         launch_r <= launch_nxt;
         cap_r    <= cap_nxt;
         smp_r    <= TAPS;
         prev_r   <= prev_nxt;
         match_r  <= match_nxt;
         iter_r   <= iter_nxt;
         dcnt_r   <= dcnt_nxt;
         err_r    <= err_nxt;
         ok_r     <= ok_nxt;
         code_r   <= code_nxt;
         vld_r    <= vld_nxt;
         done_r   <= done_nxt;
         busy_r   <= busy_nxt;
      end
   end

   assign LAUNCH   = launch_r;
   assign BUSY     = busy_r;
   assign DONE     = done_r;
   assign CODE     = code_r;
   assign CODE_VLD = vld_r;
   assign ERR      = err_r;

endmodule

// File: tb/tb_dlyc_chain_cal.sv
// Directed bench for dlyc_chain_cal with a behavioural model of the delay chain taps.
module tb_dlyc_chain_cal;

   localparam int NTAPS = 16;
   localparam int CW    = 5;

   logic             clk = 1'b0;
   logic             rn;
   logic             start;
   logic             launch, busy, done, code_vld, err;
   logic [NTAPS-1:0] taps;
   logic [CW-1:0]    code;
   wire              vdd, vss;

   assign vdd = 1'b1;
   assign vss = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;

   // chain model controls: 0 = one-cycle pulse, 1 = drains drain_n cycles after LAUNCH falls, 2 = never drains
   int               mode    = 0;
   int               drain_n = 2;
   int               dcnt_m  = 0;
   logic             alt_en  = 1'b0;
   logic             alt_ph  = 1'b0;
   logic [NTAPS-1:0] pat_a   = 16'h0000;
   logic [NTAPS-1:0] pat_b   = 16'h0000;
   logic [NTAPS-1:0] cur     = 16'h0000;
   logic             launch_q = 1'b0;

   dlyc_chain_cal dut (
      .CLK      (clk),
      .RN       (rn),
      .START    (start),
      .LAUNCH   (launch),
      .TAPS     (taps),
      .BUSY     (busy),
      .DONE     (done),
      .CODE     (code),
      .CODE_VLD (code_vld),
      .ERR      (err),
      .VDD      (vdd),
      .VSS      (vss)
   );

   always #5 clk = ~clk;

   // chain model, updated between active edges
   always @(negedge clk) begin
      if (launch && !launch_q) begin
         cur    = (alt_en && alt_ph) ? pat_b : pat_a;
         alt_ph = !alt_ph;
      end
      case (mode)
         0: taps = (launch && !launch_q) ? cur : 16'h0000;
         1: begin
            if (launch) begin
               taps   = cur;
               dcnt_m = drain_n;
            end else if (dcnt_m > 0) begin
               dcnt_m = dcnt_m - 1;
               if (dcnt_m == 0) taps = 16'h0000;
            end
         end
         default: if (launch) taps = cur;
      endcase
      launch_q = launch;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_code(input logic [CW-1:0] b);
`ifdef DLYC_CAL_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   // one START pulse, returns cycles from the accepting edge to DONE
   task automatic run_cal(output int lat);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 2000) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_val("done_seen", 32'(done), 32'd1);
   endtask

   int lat;
   int ndone;

   initial begin
      rn    = 1'b0;
      start = 1'b0;
      taps  = 16'h0000;
      repeat (3) @(negedge clk);
      check_val("rst_launch", 32'(launch), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_code", 32'(code), 32'd0);
      check_val("rst_vld", 32'(code_vld), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      rn = 1'b1;
      repeat (2) @(negedge clk);

      // stable 00FF, immediate drain: 4 iterations of 4 cycles plus FINISH
      mode = 0; pat_a = 16'h00FF; alt_en = 1'b0;
      run_cal(lat);
      check_val("t1_lat", 32'(lat), 32'd17);
      check_val("t1_code", 32'(code), 32'(exp_code(5'd8)));
      check_val("t1_vld", 32'(code_vld), 32'd1);
      check_val("t1_err", 32'(err), 32'd0);
      repeat (3) @(negedge clk);

      // alternating 7/8 never converges: MAXITER iterations then failure
      mode = 0; pat_a = 16'h007F; pat_b = 16'h00FF; alt_en = 1'b1; alt_ph = 1'b0;
      run_cal(lat);
      check_val("t2_lat", 32'(lat), 32'd65);
      check_val("t2_err", 32'(err), 32'd1);
      check_val("t2_code", 32'(code), 32'(exp_code(5'd8)));
      check_val("t2_vld", 32'(code_vld), 32'd1);
      repeat (3) @(negedge clk);

      // bubble pattern, two-cycle drain: code still published
      mode = 1; drain_n = 2; pat_a = 16'h00F7; alt_en = 1'b0;
      run_cal(lat);
      check_val("t3_code", 32'(code), 32'(exp_code(5'd3)));
      check_val("t3_err", 32'(err), 32'd1);
      check_val("t3_vld", 32'(code_vld), 32'd1);
      repeat (3) @(negedge clk);

      // saturated chain that never drains: every DRAIN runs CLR_TMO cycles
      mode = 2; pat_a = 16'hFFFF;
      run_cal(lat);
      check_val("t4_lat", 32'(lat), 32'd73);
      check_val("t4_code", 32'(code), 32'(exp_code(5'd16)));
      check_val("t4_err", 32'(err), 32'd1);
      repeat (3) @(negedge clk);

      // START pulsed mid-calibration must not add a DONE
      mode = 0; pat_a = 16'h00FF;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (c == 5) start = 1'b1;
         if (c == 6) start = 1'b0;
         if (done) ndone++;
      end
      check_val("t5_ndone", 32'(ndone), 32'd1);
      check_val("t5_code", 32'(code), 32'(exp_code(5'd8)));
      check_val("t5_err", 32'(err), 32'd0);

      // asynchronous reset in the first DRAIN cycle while LAUNCH is high
      mode = 2; pat_a = 16'h00FF;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("t6_launch_hi", 32'(launch), 32'd1);
      check_val("t6_busy_hi", 32'(busy), 32'd1);
      rn = 1'b0;
      #1;
      check_val("t6_launch", 32'(launch), 32'd0);
      check_val("t6_busy", 32'(busy), 32'd0);
      check_val("t6_done", 32'(done), 32'd0);
      check_val("t6_code", 32'(code), 32'd0);
      check_val("t6_vld", 32'(code_vld), 32'd0);
      check_val("t6_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      rn = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dlyc_chain_cal.md
Name: dlyc_chain_cal

Overview:
- Calibration controller downstream of a chain of NTAPS dlyc_4 delay cells.
- Launches a rising edge into the chain input, samples every tap output one CLK period later, and converts the thermometer pattern into a tap count.
- Filters successive measurements and publishes a stable delay code (taps per clock period) for delay-line tuning logic.

Parameters:
- NTAPS, 16, number of dlyc_4 cells in the measured chain (tap i = Z of cell i).
- CW, $clog2(NTAPS+1), width of CODE.
- FILT, 4, consecutive identical measurements required before CODE updates (2..15).
- MAXITER, 16, measurement attempts per START before giving up.
- CLR_TMO, 15, max cycles to wait for the chain to drain low.

Ports:
- CLK  in  1  clock.
- RN  in  1  asynchronous active-low reset.
- START  in  1  calibration request; sampled in IDLE only.
- LAUNCH  out  1  drives I of the first dlyc_4 in the chain; registered.
- TAPS  in  NTAPS  Z outputs of the chain cells, tap0 nearest LAUNCH.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at end of calibration.
- CODE  out  CW  calibrated tap count; held between calibrations.
- CODE_VLD  out  1  set on first successful calibration; cleared only by reset.
- ERR  out  1  bubble, drain timeout or no convergence in last calibration; sticky until next accepted START.
- VDD  inout  1  power.
- VSS  inout  1  ground.

Behaviour:
- Clocking: one clock CLK; reset RN is asynchronous and active-low.
- Reset values: LAUNCH=0, BUSY=0, DONE=0, CODE=0, CODE_VLD=0, ERR=0; FSM=IDLE; all counters 0.
- Reset asserted mid-operation aborts immediately; LAUNCH drops asynchronously.
- FSM states: IDLE, LAUNCH, CAPT, EVAL, DRAIN, FINISH.
- IDLE: START=1 -> LAUNCH. Clears ERR, iteration counter and match counter.
- LAUNCH: sets LAUNCH=1 at this edge -> CAPT.
  - TAPS is registered at the next edge, exactly one CLK period after LAUNCH rises.
- CAPT: holds the captured register -> EVAL.
- EVAL: meas = count of consecutive ones starting at tap0 (0..NTAPS).
  - All ones -> meas=NTAPS (saturated).
  - Any 1 above the first 0 is a bubble: set ERR, keep meas.
  - meas == prev: increment match counter. Otherwise reload match counter with 1 and set prev=meas.
  - Increment iteration counter. -> DRAIN.
- DRAIN: LAUNCH=0. Wait until a registered TAPS sample is all zero -> decide next state.
  - Timeout after CLR_TMO cycles sets ERR and still proceeds.
  - Match counter == FILT -> FINISH with success.
  - Iteration counter == MAXITER -> FINISH with failure (ERR=1).
  - Otherwise -> LAUNCH.
- FINISH:
  - On success: CODE <= prev, CODE_VLD <= 1.
  - On failure: CODE unchanged.
  - DONE=1 for one cycle -> IDLE.
- START outside IDLE is ignored; no queuing.
- START held high re-triggers a new calibration on the cycle after DONE.
- Success latency with stable taps and immediate drain: FILT×4 + 1 cycles from START accept to DONE.
- A bubble sets ERR but does not block success; the code is still published.

Optional Feature:
- Macro: DLYC_CAL_GRAY_EN.
- Defined: CODE is presented Gray-encoded (bin ^ (bin>>1)), registered together with CODE_VLD, for a consumer in another clock domain. Internal comparison stays binary.
- Undefined: CODE is plain binary.

Decomposition:
- Package dlyc_cal_pkg:
  - FSM state enum.
  - Function clog2-based CW helper.
  - Function bin2gray.
  - Default constants FILT_DEF and MAXITER_DEF.
- Sub-module dlyc_therm_dec (combinational): TAPS -> meas[CW-1:0], bubble flag. Parameter NTAPS.

Test Plan:
- NTAPS=16; TAPS model returns 16'h00FF every launch, drains in 2 cycles; START pulse -> DONE after 4 iterations, CODE=8, CODE_VLD=1, ERR=0.
- Taps alternate 16'h007F / 16'h00FF per launch -> MAXITER reached, DONE with ERR=1, CODE keeps prior value 8.
- Taps 16'h00F7 (bubble) stable -> CODE=3, ERR=1, CODE_VLD=1.
- Taps 16'hFFFF stable -> CODE=16. Taps never drain -> each DRAIN lasts CLR_TMO cycles and ERR=1.
- Assert RN low during DRAIN with LAUNCH=1 -> LAUNCH, BUSY, DONE, CODE, CODE_VLD=0 immediately. START during BUSY produces no extra DONE.
- DLYC_CAL_GRAY_EN defined, stable 16'h00FF -> CODE=4'b1100 (gray of 8) on 5-bit bus = 5'b01100.
